// File: rtl/dds_pkg.sv
// Shared types and constants for the sweep-DDS phase generator.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_SAW     = 2'b01;
    localparam logic [1:0] MODE_TRI     = 2'b10;

    // Mode 11 is an alias of one-shot.
    function automatic logic is_oneshot(input logic [1:0] mode);
        return (mode == MODE_ONESHOT) || (mode == 2'b11);
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with synchronous clear and registered, offset ROM address.
module dds_phase_acc #(
    parameter int ACC_W  = 32,
    parameter int FW_W   = 24,
    parameter int ADDR_W = 14
) (
    input  logic              clk_wave,
    input  logic              sys_rst,
    input  logic              i_clear,
    input  logic [FW_W-1:0]   i_fword,
    input  logic [ADDR_W-1:0] i_phase_off,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ACC_W-1:0]  r_acc;
    logic [ADDR_W-1:0] r_addr;
    logic [ACC_W-1:0]  w_fword_ext;

    assign w_fword_ext = ACC_W'(i_fword);

    // Accumulate the frequency word every cycle; a sweep start restarts phase at zero.
    always_ff @(posedge clk_wave or negedge sys_rst) begin
        if (!sys_rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values; blocking here would race the addr register below.
            r_acc <= r_acc + w_fword_ext;
        end
    end

    // Address is the top accumulator bits plus offset, wrapping modulo 2^ADDR_W.
    always_ff @(posedge clk_wave or negedge sys_rst) begin
        if (!sys_rst) begin
            r_addr <= '0;
        end else begin
            r_addr <= r_acc[ACC_W-1 -: ADDR_W] + i_phase_off;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/dds_sweep_gen.sv
// Sweep-DDS phase generator: sweep FSM, dwell timer, step/clamp arithmetic, config latches.
module dds_sweep_gen #(
    parameter int ACC_W   = 32,
    parameter int FW_W    = 24,
    parameter int ADDR_W  = 14,
    parameter int DWELL_W = 16
) (
    input  logic               clk_wave,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [FW_W-1:0]    f_start,
    input  logic [FW_W-1:0]    f_stop,
    input  logic [FW_W-1:0]    f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ADDR_W-1:0]  phase_off,
    output logic [ADDR_W-1:0]  addr,
    output logic [FW_W-1:0]    fword,
    output logic               busy,
    output logic               done,
    output logic               step_tick
);

    import dds_pkg::*;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_mode;
    logic [FW_W-1:0]    r_f_start, r_f_stop, r_f_step, r_fword;
    logic [DWELL_W-1:0] r_dwell, r_dwell_cnt;
    logic               r_dir_up, r_at_end, r_done, r_step_tick;

    logic               w_busy, w_load, w_step;
    logic               w_turn, w_restart, w_eff_up, w_arrive, w_done_nxt;
    logic [FW_W-1:0]    w_eff_start, w_eff_stop, w_fword_nxt;
    logic [FW_W:0]      w_sum, w_diff;

    // State register.
    always_ff @(posedge clk_wave or negedge sys_rst) begin
        if (!sys_rst) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: stop always wins; one-shot parks in HOLD on endpoint arrival.
    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (start) w_state_nxt = RUN;
                RUN:     if (w_step && w_done_nxt && is_oneshot(r_mode)) w_state_nxt = HOLD;
                HOLD:    if (start) w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: busy, config load on accepted start, step strobe on dwell expiry.
    always_comb begin
        w_busy = (r_state == RUN);
        w_load = start && !stop && (r_state != RUN);
        w_step = w_busy && !stop && (r_dwell_cnt == r_dwell);
    end

    // Step arithmetic in FW_W+1 bits; a triangle turnaround swaps endpoints before stepping.
    always_comb begin
        w_turn      = r_at_end && (r_mode == MODE_TRI);
        w_restart   = r_at_end && (r_mode == MODE_SAW);
        w_eff_up    = r_dir_up ^ w_turn;
        w_eff_start = w_turn ? r_f_stop  : r_f_start;
        w_eff_stop  = w_turn ? r_f_start : r_f_stop;
        w_sum       = {1'b0, r_fword} + {1'b0, r_f_step};
        w_diff      = {1'b0, r_fword} - {1'b0, r_f_step};
        w_arrive    = (r_f_step == '0) ||
                      (w_eff_up ? (w_sum >= {1'b0, w_eff_stop})
                                : (w_diff[FW_W] || (w_diff[FW_W-1:0] <= w_eff_stop)));
        if (w_restart)     w_fword_nxt = r_f_start;
        else if (w_arrive) w_fword_nxt = w_eff_stop;
        else if (w_eff_up) w_fword_nxt = w_sum[FW_W-1:0];
        else               w_fword_nxt = w_diff[FW_W-1:0];
        w_done_nxt  = w_arrive && !w_restart;
    end

    // Config latches, frequency word, dwell counter and the done/step_tick pulses.
    always_ff @(posedge clk_wave or negedge sys_rst) begin
        if (!sys_rst) begin
            // NOTE: config latches are reset as well, so no X ever reaches the step logic before the first start.
            r_mode      <= MODE_ONESHOT;
            r_f_start   <= '0;
            r_f_stop    <= '0;
            r_f_step    <= '0;
            r_dwell     <= '0;
            r_dir_up    <= 1'b1;
            r_at_end    <= 1'b0;
            r_fword     <= '0;
            r_dwell_cnt <= '0;
            r_done      <= 1'b0;
            r_step_tick <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_step_tick <= 1'b0;
            if (w_load) begin
                r_mode      <= mode;
                r_f_start   <= f_start;
                r_f_stop    <= f_stop;
                r_f_step    <= f_step;
                r_dwell     <= dwell;
                r_dir_up    <= (f_stop >= f_start);
                r_at_end    <= 1'b0;
                r_fword     <= f_start;
                r_dwell_cnt <= '0;
                r_step_tick <= 1'b1;
            end else if (w_step) begin
                r_f_start   <= w_eff_start;
                r_f_stop    <= w_eff_stop;
                r_dir_up    <= w_eff_up;
                r_at_end    <= w_done_nxt;
                r_fword     <= w_fword_nxt;
                r_dwell_cnt <= '0;
                r_done      <= w_done_nxt;
                r_step_tick <= 1'b1;
            end else if (w_busy && !stop) begin
                r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
            end
        end
    end

    dds_phase_acc #(
        .ACC_W  (ACC_W),
        .FW_W   (FW_W),
        .ADDR_W (ADDR_W)
    ) u_phase_acc (
        .clk_wave    (clk_wave),
        .sys_rst     (sys_rst),
        .i_clear     (w_load),
        .i_fword     (r_fword),
        .i_phase_off (phase_off),
        .o_addr      (addr)
    );

    assign fword     = r_fword;
    assign busy      = w_busy;
    assign done      = r_done;
    assign step_tick = r_step_tick;

endmodule

// File: tb/tb_dds_sweep_gen.sv
// Scoreboard bench for dds_sweep_gen: a sweep-level model queues the expected fword
// updates, and an independent monitor checks each step_tick against the queue head.
module tb_dds_sweep_gen;

    localparam int ACC_W   = 32;
    localparam int FW_W    = 24;
    localparam int ADDR_W  = 14;
    localparam int DWELL_W = 16;

    logic               clk_wave = 1'b0;
    logic               sys_rst  = 1'b1;
    logic               start    = 1'b0;
    logic               stop     = 1'b0;
    logic [1:0]         mode     = '0;
    logic [FW_W-1:0]    f_start  = '0;
    logic [FW_W-1:0]    f_stop   = '0;
    logic [FW_W-1:0]    f_step   = '0;
    logic [DWELL_W-1:0] dwell    = '0;
    logic [ADDR_W-1:0]  phase_off = '0;
    logic [ADDR_W-1:0]  addr;
    logic [FW_W-1:0]    fword;
    logic               busy, done, step_tick;

    always #5 clk_wave = ~clk_wave;

    dds_sweep_gen #(
        .ACC_W   (ACC_W),
        .FW_W    (FW_W),
        .ADDR_W  (ADDR_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk_wave  (clk_wave),
        .sys_rst   (sys_rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .phase_off (phase_off),
        .addr      (addr),
        .fword     (fword),
        .busy      (busy),
        .done      (done),
        .step_tick (step_tick)
    );

    typedef struct {
        logic [FW_W-1:0] fword;
        logic            done;
        logic            busy;
        int              gap;   // expected cycles since previous tick, 0 = not checked
    } exp_t;

    exp_t            exp_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              cycle   = 0;
    int              last_tick = 0;
    logic [FW_W-1:0] last_seen = '0;
    logic [FW_W-1:0] last_model_fw = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic void push_exp(input longint fw, input bit d, input bit b, input int gap);
        exp_t e;
        e.fword = FW_W'(fw);
        e.done  = d;
        e.busy  = b;
        e.gap   = gap;
        exp_q.push_back(e);
    endfunction

    // Sweep-level model: walks the frequency word between the two endpoints with plain
    // integer arithmetic and records n expected updates (fewer if a one-shot finishes).
    function automatic void model_sweep(input logic [1:0] m, input longint fs, input longint fe,
                                        input longint st, input int dw, input int n);
        longint a = fs;
        longint b = fe;
        longint cur = fs;
        longint nx, tmp;
        bit up = (fe >= fs);
        bit arrived = 1'b0;
        bit one = (m == 2'd0) || (m == 2'd3);
        push_exp(cur, 1'b0, 1'b1, 0);
        for (int k = 1; k < n; k++) begin
            if (arrived && m == 2'd1) begin
                cur = a;
                arrived = 1'b0;
                push_exp(cur, 1'b0, 1'b1, dw + 1);
                continue;
            end
            if (arrived && m == 2'd2) begin
                tmp = a; a = b; b = tmp;
                up = !up;
                arrived = 1'b0;
            end
            nx = up ? cur + st : cur - st;
            if (st == 0 || (up && nx >= b) || (!up && nx <= b)) begin
                cur = b;
                arrived = 1'b1;
            end else begin
                cur = nx;
            end
            push_exp(cur, arrived, !(one && arrived), dw + 1);
            if (one && arrived) break;
        end
        last_model_fw = FW_W'(cur);
    endfunction

    // Monitor: compares every fword update against the scoreboard head.
    always @(posedge clk_wave) begin
        exp_t e;
        cycle++;
        #1;
        if (sys_rst) begin
            if (step_tick) begin
                if (exp_q.size() == 0) begin
                    check("unexpected step_tick", step_tick, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("fword", fword, e.fword);
                    check("done", done, e.done);
                    check("busy at tick", busy, e.busy);
                    if (e.gap != 0) check("tick spacing", cycle - last_tick, e.gap);
                    last_tick = cycle;
                    last_seen = fword;
                end
            end else if (done) begin
                check("done without step_tick", done, 1'b0);
            end
        end
    end

    // All stimulus tasks are entered and left at a falling edge.
    task automatic launch(input logic [1:0] m, input longint fs, input longint fe,
                          input longint st, input int dw, input int n);
        model_sweep(m, fs, fe, st, dw, n);
        mode    = m;
        f_start = FW_W'(fs);
        f_stop  = FW_W'(fe);
        f_step  = FW_W'(st);
        dwell   = DWELL_W'(dw);
        start   = 1'b1;
        @(negedge clk_wave);
        start   = 1'b0;
        mode    = 2'($urandom);
        f_start = FW_W'($urandom);
        f_stop  = FW_W'($urandom);
        f_step  = FW_W'($urandom);
        dwell   = DWELL_W'($urandom_range(0, 7));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int left = budget;
        while (exp_q.size() != 0 && left > 0) begin
            @(negedge clk_wave);
            left--;
        end
        check({name, " drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk_wave);
        stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]        m;
        longint            fs, fe, st, d;
        int                dw, n, bad, wrap_seen;
        logic [ADDR_W-1:0] prev;
        bit                one;

        // Reset state
        #1 sys_rst = 1'b0;
        #1;
        check("reset addr", addr, 0);
        check("reset fword", fword, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset step_tick", step_tick, 0);
        @(negedge clk_wave);
        @(negedge clk_wave);
        sys_rst = 1'b1;
        @(negedge clk_wave);

        // One-shot upward sweep ending in HOLD
        phase_off = 14'd7;
        launch(2'd0, 100, 400, 100, 3, 20);
        wait_drain("oneshot up", 40);
        repeat (4) @(negedge clk_wave);
        check("oneshot hold busy", busy, 0);
        check("oneshot hold fword", fword, 400);

        // Sawtooth downward sweep, dwell 0
        launch(2'd1, 400, 100, 150, 0, 7);
        wait_drain("saw down", 30);
        pulse_stop();
        repeat (2) @(negedge clk_wave);
        check("saw stop busy", busy, 0);
        check("saw stop fword", fword, last_model_fw);

        // Triangle sweep
        launch(2'd2, 10, 30, 10, 1, 9);
        wait_drain("triangle", 40);
        check("triangle busy", busy, 1);
        pulse_stop();

        // Zero step: first step is an endpoint arrival
        launch(2'd1, 50, 500, 0, 2, 5);
        wait_drain("step zero", 40);
        pulse_stop();

        // Start while running is ignored
        launch(2'd1, 1000, 5000, 1000, 2, 12);
        repeat (4) @(negedge clk_wave);
        mode = 2'd2; f_start = 24'd7; f_stop = 24'd9; f_step = 24'd1; dwell = 16'd0;
        start = 1'b1;
        @(negedge clk_wave);
        start = 1'b0;
        wait_drain("start in RUN", 60);
        pulse_stop();

        // Stop and start in the same cycle, from RUN then from IDLE
        launch(2'd1, 200, 800, 100, 1, 100);
        repeat (6) @(negedge clk_wave);
        exp_q.delete();
        stop = 1'b1; start = 1'b1;
        @(negedge clk_wave);
        stop = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk_wave);
        check("stop+start from RUN busy", busy, 0);
        check("stop+start keeps fword", fword, last_seen);
        stop = 1'b1; start = 1'b1;
        @(negedge clk_wave);
        stop = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk_wave);
        check("stop+start from IDLE busy", busy, 0);

        // Address stepping and wrap at fword = 2^22
        phase_off = '0;
        launch(2'd0, 1 << 22, 1 << 22, 1, 0, 5);
        wait_drain("addr tone", 10);
        prev = addr;
        bad = 0;
        wrap_seen = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk_wave);
            if (ADDR_W'(addr - prev) != ADDR_W'(16)) bad++;
            if (prev == 14'd16368 && addr == 14'd0) wrap_seen = 1;
            prev = addr;
        end
        check("addr steps of 16", bad, 0);
        check("addr wrap 16368->0", wrap_seen, 1);
        phase_off = 14'd5;
        repeat (2) @(negedge clk_wave);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (addr[3:0] != 4'd5) bad++;
            @(negedge clk_wave);
        end
        check("phase offset applied", bad, 0);

        // Reset in the middle of a sweep
        phase_off = 14'd37;
        launch(2'd1, 1000, 9000, 500, 1, 50);
        repeat (5) @(negedge clk_wave);
        @(posedge clk_wave);
        #2 sys_rst = 1'b0;
        #1;
        check("mid-run reset addr", addr, 0);
        check("mid-run reset fword", fword, 0);
        check("mid-run reset busy", busy, 0);
        check("mid-run reset done", done, 0);
        check("mid-run reset step_tick", step_tick, 0);
        exp_q.delete();
        @(negedge clk_wave);
        @(negedge clk_wave);
        sys_rst = 1'b1;
        repeat (3) @(negedge clk_wave);
        check("post-reset fword", fword, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (addr != 14'd37) bad++;
            @(negedge clk_wave);
        end
        check("post-reset addr == phase_off", bad, 0);

        // Randomized sweeps
        for (int t = 0; t < 30; t++) begin
            m  = 2'($urandom_range(0, 3));
            fs = longint'($urandom_range(0, (1 << FW_W) - 1));
            fe = ($urandom_range(0, 7) == 0) ? fs : longint'($urandom_range(0, (1 << FW_W) - 1));
            d  = (fe > fs) ? fe - fs : fs - fe;
            st = ($urandom_range(0, 7) == 0) ? 0 : d / longint'($urandom_range(2, 6)) + longint'($urandom_range(1, 50));
            dw = int'($urandom_range(0, 4));
            one = (m == 2'd0) || (m == 2'd3);
            n  = one ? 20 : int'($urandom_range(4, 14));
            phase_off = ADDR_W'($urandom);
            launch(m, fs, fe, st, dw, n);
            wait_drain("random sweep", n * (dw + 1) + 20);
            if (one) begin
                repeat (3) @(negedge clk_wave);
                check("random oneshot busy", busy, 0);
                check("random oneshot fword", fword, last_model_fw);
                if ($urandom_range(0, 1) == 1) pulse_stop();
            end else begin
                pulse_stop();
                repeat (2) @(negedge clk_wave);
                check("random stop busy", busy, 0);
                check("random stop fword", fword, last_model_fw);
            end
        end

        repeat (3) @(negedge clk_wave);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
